// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and helpers for the APB completer memory.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Completer phase tracking: IDLE waits for SETUP, ACCESS serves the beat.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    // Byte-to-word shift for 16-bit words (2-byte stride).
    localparam int APB_WORD_SHIFT = 1;

    // Flags a misaligned byte address or any address bit above the word index.
    // The caller zero-extends its address to 64 bits.
    function automatic logic addr_err(input logic [63:0] addr, input int idx_bits);
        return addr[0] | (|(addr >> (APB_WORD_SHIFT + idx_bits)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regfile
// Description : MEM_DEPTH x DATA_WIDTH register memory, one synchronous write
//               port, one combinational read port, async clear to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                         i_pclk,
    input  logic                         i_prst_n,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_wr_idx,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_rd_idx,
    output logic [DATA_WIDTH-1:0]        o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Word storage: cleared on reset, written one word per cycle.
    always_ff @(posedge i_pclk or negedge i_prst_n) begin
        if (!i_prst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB completer with programmable wait states, address error
//               reporting and master protocol-violation detection.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int MAX_WAIT   = 15
) (
    input  logic                           i_pclk,
    input  logic                           i_prst_n,
    input  logic                           i_psel,
    input  logic                           i_pen,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwr_data,
    input  logic [$clog2(MAX_WAIT+1)-1:0]  i_wait_cfg,
    output logic                           o_pready,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pslver,
    output logic                           o_viol
);

    localparam int c_IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int c_WAIT_BITS = $clog2(MAX_WAIT + 1);

    apb_slv_state_e          r_state;
    logic [c_WAIT_BITS-1:0]  r_wait_cnt;
    logic [c_IDX_BITS-1:0]   r_idx;
    logic                    r_err;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_viol;
    // Previous-cycle samples of the address/control/data inputs, so a change
    // during ACCESS is reported once rather than on every cycle it persists.
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic                    r_write_q;
    logic [DATA_WIDTH-1:0]   r_wdata_q;

    logic [c_IDX_BITS-1:0]   w_idx;
    logic                    w_err;
    logic [c_WAIT_BITS:0]    w_wait_ext;
    logic [c_WAIT_BITS-1:0]  w_wait_load;
    logic                    w_in_changed;
    logic                    w_ready;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_idx        = i_paddr[APB_WORD_SHIFT +: c_IDX_BITS];
    assign w_err        = addr_err(64'(i_paddr), c_IDX_BITS);
    // Widened by one bit so the saturation compare stays meaningful even when
    // MAX_WAIT fills the configuration field.
    assign w_wait_ext   = {1'b0, i_wait_cfg};
    assign w_wait_load  = (w_wait_ext > (c_WAIT_BITS+1)'(MAX_WAIT)) ?
                          c_WAIT_BITS'(MAX_WAIT) : i_wait_cfg;
    assign w_in_changed = (i_paddr != r_addr_q) | (i_pwrite != r_write_q) |
                          (i_pwr_data != r_wdata_q);
    // Ready is decoded purely from flops so there is no input-to-output path.
    assign w_ready      = (r_state == ACCESS) && (r_wait_cnt == '0);
    assign w_wr_en      = w_ready && i_psel && i_pen && r_write && !r_err;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_regfile (
        .i_pclk    (i_pclk),
        .i_prst_n  (i_prst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_data (r_wdata),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data)
    );

    // Transfer FSM: SETUP capture, wait-state countdown, completion, violations.
    always_ff @(posedge i_pclk or negedge i_prst_n) begin
        if (!i_prst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_prdata   <= '0;
            r_viol     <= 1'b0;
            r_addr_q   <= '0;
            r_write_q  <= 1'b0;
            r_wdata_q  <= '0;
        end else begin
            r_viol    <= 1'b0;
            r_addr_q  <= i_paddr;
            r_write_q <= i_pwrite;
            r_wdata_q <= i_pwr_data;
            case (r_state)
                IDLE: begin
                    if (i_psel && !i_pen) begin
                        r_idx      <= w_idx;
                        r_err      <= w_err;
                        r_write    <= i_pwrite;
                        r_wdata    <= i_pwr_data;
                        r_wait_cnt <= w_wait_load;
                        r_state    <= ACCESS;
                        // Read data is fetched at SETUP and held until the
                        // next read SETUP.
                        if (!i_pwrite) begin
                            r_prdata <= w_err ? '0 : w_rd_data;
                        end
                    end else if (i_psel && i_pen) begin
                        // ENABLE without a preceding SETUP.
                        r_viol <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!i_psel) begin
                        // Master abandoned the transfer: abort, nothing written.
                        r_viol  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        if (w_in_changed) begin
                            r_viol <= 1'b1;
                        end
                        if (i_pen) begin
                            if (r_wait_cnt != '0) begin
                                r_wait_cnt <= r_wait_cnt - 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pready = w_ready;
    assign o_pslver = w_ready && r_err;
    assign o_prdata = r_prdata;
    assign o_viol   = r_viol;

endmodule
`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer: the responder end for the team's apb_master. It decodes SETUP/ACCESS phases, inserts a programmable number of wait states, and serves reads and writes from an internal register memory.
- Signals PSLVERR-style errors for misaligned or out-of-range addresses.
- Used as the synthesizable slave in system builds and as the reference responder in master regressions.

Parameters:
- DATA_WIDTH, 16, PWDATA/PRDATA width.
- ADDR_WIDTH, 32, PADDR width (byte address).
- MEM_DEPTH, 64, number of DATA_WIDTH words. Power of 2, ≥2.
- MAX_WAIT, 15, upper bound of i_wait_cfg. Sets the counter width, clog2(MAX_WAIT+1).

Ports:
- i_pclk, in, 1, clock.
- i_prst_n, in, 1, asynchronous active-low reset.
- i_psel, in, 1, APB select.
- i_pen, in, 1, APB enable.
- i_pwrite, in, 1, 1=write, 0=read.
- i_paddr, in, ADDR_WIDTH, byte address.
- i_pwr_data, in, DATA_WIDTH, write data.
- i_wait_cfg, in, clog2(MAX_WAIT+1), wait states per transfer. Sampled in SETUP.
- o_pready, out, 1, transfer-complete.
- o_prdata, out, DATA_WIDTH, read data. Valid when o_pready && !o_pslver on a read.
- o_pslver, out, 1, slave error. Valid only with o_pready.
- o_viol, out, 1, one-cycle pulse on master protocol violation.

Behaviour:
- Clock/reset (already decided): one clock, i_pclk. Reset is asynchronous, active-low, on i_prst_n.
- Reset values:
  - state=IDLE, wait_cnt=0.
  - o_pready=0, o_prdata=0, o_pslver=0, o_viol=0.
  - All MEM_DEPTH words = 0.
- Address decode:
  - Word stride is 2 bytes.
  - idx = i_paddr[1 +: log2(MEM_DEPTH)].
  - err = i_paddr[0] | (|i_paddr[ADDR_WIDTH-1 : 1+log2(MEM_DEPTH)]).
- IDLE:
  - Edge with i_psel=1, i_pen=0: latch addr/idx/err, i_pwrite and i_pwr_data. Load wait_cnt=i_wait_cfg. Go to ACCESS.
  - For a read, o_prdata <= err ? 0 : mem[idx] at this same edge.
  - Edge with i_psel=1, i_pen=1 while in IDLE (no SETUP seen): o_viol pulses. Stay IDLE, no response.
- ACCESS:
  - o_pready = (state==ACCESS) && (wait_cnt==0). Decoded from flops only, no input paths.
  - o_pslver = o_pready && err_latched.
  - Edge with i_psel&i_pen and wait_cnt>0: wait_cnt decrements.
  - Edge with i_psel&i_pen&o_pready:
    - Write with no error: mem[idx] <= latched wdata.
    - Write with error: memory unchanged.
    - Go to IDLE.
  - Latency:
    - i_wait_cfg=0 gives the standard 2-cycle transfer (SETUP + one ACCESS).
    - N wait states give 2+N cycles.
- Latched values are used throughout ACCESS. Changes on i_paddr, i_pwrite or i_pwr_data during ACCESS are ignored, and each change pulses o_viol once.
- i_psel=0 in ACCESS before completion: abort with no write, go to IDLE, o_viol pulses.
- Read data: o_prdata holds its value after completion until the next read SETUP. An error read returns 0.
- Back-to-back transfers: after completion the next SETUP is sampled from IDLE on the following edge, so there are no dead cycles beyond the APB minimum.
- Reset mid-transfer: immediate return to IDLE. The pending write is discarded; memory returns to 0.
- i_wait_cfg > MAX_WAIT is saturated to MAX_WAIT.

Decomposition:
- Package apb_pkg holds:
  - enum apb_slv_state_e {IDLE, ACCESS};
  - localparam APB_WORD_SHIFT=1;
  - the function computing addr_err.
- Sub-module apb_slave_regfile:
  - MEM_DEPTH x DATA_WIDTH.
  - One write port, one read port.
  - Async reset to 0.
- The FSM, wait counter and violation checks stay in apb_slave_mem.

Test Plan:
- Zero-wait write then read: write 0x0004 = 0xA5A5 with wait_cfg=0.
  - o_pready is high in the first ACCESS cycle.
  - The read of 0x0004 returns 0xA5A5 with o_pslver=0.
- Wait states: wait_cfg=3, write 0x0010 = 0x1234, then read 0x0010.
  - o_pready stays low for exactly 3 ACCESS cycles, then is high for 1.
  - The read returns 0x1234.
- Errors:
  - Write 0xFFFC = 0xDEAD (out of range): o_pready=1 and o_pslver=1.
  - The following read of 0xFFFC returns 0 with o_pslver=1.
  - Write 0x0005 (misaligned): o_pslver=1, and mem[2] is unchanged.
- Violations:
  - Change i_paddr from 0x0010 to 0x0020 during ACCESS: o_viol pulses once, and 0x0010 is written.
  - Drop i_psel during wait states: o_viol pulses, no write, state returns to IDLE.
- Reset mid-transfer: assert i_prst_n=0 during ACCESS of write 0x0008 = 0xBEEF.
  - Outputs go to 0 immediately.
  - After release, a read of 0x0008 returns 0.
- Back-to-back: 16 writes to 0x0000..0x001E followed by 16 reads with wait_cfg=0.
  - Every transfer completes in 2 cycles.
  - All data matches.
